// File: rtl/y_mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control/PC sequencer.
package y_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // Instruction classes recognised by the decoder
    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_IALU  = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_JAL   = 3'd5,
        CLS_BAD   = 3'd6
    } ins_class_t;

    // Major opcodes (ins[6:0])
    localparam logic [6:0] OPC_R     = 7'h33;
    localparam logic [6:0] OPC_IALU  = 7'h13;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_BEQ   = 7'h63;
    localparam logic [6:0] OPC_JAL   = 7'h6F;

    // ALU operation codes understood by yEX
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Map opcode (plus funct3 for branches) onto an instruction class.
    // Only beq is implemented among the branches, so other funct3 values are illegal.
    function automatic ins_class_t classify(input logic [6:0] opc, input logic [2:0] funct3);
        ins_class_t cls;
        case (opc)
            OPC_R:     cls = CLS_R;
            OPC_IALU:  cls = CLS_IALU;
            OPC_LOAD:  cls = CLS_LOAD;
            OPC_STORE: cls = CLS_STORE;
            OPC_BEQ:   cls = (funct3 == 3'b000) ? CLS_BEQ : CLS_BAD;
            OPC_JAL:   cls = CLS_JAL;
            default:   cls = CLS_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/y_mc_ctrl_if.sv
// Bundle of datapath-facing signals between the controller and yIF/yID/yEX/yDM.
interface y_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ins;
    logic             zero;
    logic [31:0]      PCp4;
    logic [31:0]      branch;
    logic [31:0]      jTarget;
    logic             dm_ready;
    logic [31:0]      PCin;
    logic             RegWrite;
    logic             ALUSrc;
    logic [2:0]       op;
    logic             MemRead;
    logic             MemWrite;
    logic             Mem2Reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    // Controller side
    modport master (
        input  ins, zero, PCp4, branch, jTarget, dm_ready,
        output PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, illegal, retired
    );

    // Datapath side
    modport slave (
        output ins, zero, PCp4, branch, jTarget, dm_ready,
        input  PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, illegal, retired
    );
endinterface

// File: rtl/y_mc_ctrl_alu_dec.sv
// ALU operation decoder: instruction class + funct3 + funct7[5] -> ALU op.
module y_alu_dec
    import y_ctrl_pkg::*;
(
    input  ins_class_t cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] op,
    output logic       bad_funct
);

    // Register/immediate ALU ops share one funct3 table; only R-type may select sub
    always_comb begin
        op        = ALU_ADD;
        bad_funct = 1'b0;
        case (cls)
            CLS_R, CLS_IALU: begin
                case (funct3)
                    3'b000:  op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: bad_funct = 1'b1;
                endcase
            end
            CLS_BEQ: op = ALU_SUB;
            default: op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle control and PC sequencer for the yIF/yID/yEX/yDM/yWB datapath.
// All control outputs are registered Moore decodes of state and latched class.
module y_mc_ctrl
    import y_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h28,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    y_mc_ctrl_if.master bus
);

    state_t           state_reg;
    ins_class_t       cls_reg;
    logic [31:0]      pc_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             illegal_reg;
    logic             reg_write_reg;
    logic             alu_src_reg;
    logic [2:0]       op_reg;
    logic             mem_read_reg;
    logic             mem_write_reg;
    logic             mem2reg_reg;

    ins_class_t       dec_cls;
    logic [2:0]       dec_op;
    logic             dec_bad_funct;
    logic [CNT_W-1:0] retired_inc;
    logic             unused_ins;

    // Classification happens from the live instruction while in DECODE;
    // the result is captured so EXEC onward never looks at ins again.
    assign dec_cls     = classify(bus.ins[6:0], bus.ins[14:12]);
    assign retired_inc = retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    assign unused_ins  = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

    y_alu_dec u_alu_dec (
        .cls       (dec_cls),
        .funct3    (bus.ins[14:12]),
        .funct7_5  (bus.ins[30]),
        .op        (dec_op),
        .bad_funct (dec_bad_funct)
    );

    // Main sequencer: state, latched class, PC, retired counter and all strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FETCH;
            cls_reg       <= CLS_R;
            pc_reg        <= RESET_PC;
            retired_reg   <= '0;
            illegal_reg   <= 1'b0;
            reg_write_reg <= 1'b0;
            alu_src_reg   <= 1'b0;
            op_reg        <= ALU_ADD;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem2reg_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    state_reg <= DECODE;
                end

                DECODE: begin
                    cls_reg <= dec_cls;
                    if (dec_cls == CLS_BAD || dec_bad_funct) begin
                        state_reg   <= TRAP;
                        illegal_reg <= 1'b1;
                    end else begin
                        state_reg   <= EXEC;
                        op_reg      <= dec_op;
                        alu_src_reg <= !(dec_cls == CLS_R || dec_cls == CLS_BEQ);
                    end
                end

                EXEC: begin
                    case (cls_reg)
                        CLS_LOAD: begin
                            state_reg    <= MEM;
                            mem_read_reg <= 1'b1;
                        end
                        CLS_STORE: begin
                            state_reg     <= MEM;
                            mem_write_reg <= 1'b1;
                        end
                        CLS_BEQ: begin
                            state_reg   <= FETCH;
                            pc_reg      <= bus.zero ? bus.branch : bus.PCp4;
                            retired_reg <= retired_inc;
                            alu_src_reg <= 1'b0;
                            op_reg      <= ALU_ADD;
                        end
                        default: begin
                            state_reg     <= WB;
                            reg_write_reg <= 1'b1;
                            mem2reg_reg   <= 1'b0;
                        end
                    endcase
                end

                // Request is held until the memory reports completion
                MEM: begin
                    if (bus.dm_ready) begin
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        if (cls_reg == CLS_LOAD) begin
                            state_reg     <= WB;
                            reg_write_reg <= 1'b1;
                            mem2reg_reg   <= 1'b1;
                        end else begin
                            state_reg   <= FETCH;
                            pc_reg      <= bus.PCp4;
                            retired_reg <= retired_inc;
                            alu_src_reg <= 1'b0;
                            op_reg      <= ALU_ADD;
                        end
                    end
                end

                WB: begin
                    state_reg     <= FETCH;
                    reg_write_reg <= 1'b0;
                    mem2reg_reg   <= 1'b0;
                    pc_reg        <= (cls_reg == CLS_JAL) ? bus.jTarget : bus.PCp4;
                    retired_reg   <= retired_inc;
                    alu_src_reg   <= 1'b0;
                    op_reg        <= ALU_ADD;
                end

                TRAP: begin
                    state_reg <= TRAP;
                end

                default: begin
                    state_reg   <= TRAP;
                    illegal_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.PCin     = pc_reg;
    assign bus.retired  = retired_reg;
    assign bus.illegal  = illegal_reg;
    assign bus.RegWrite = reg_write_reg;
    assign bus.ALUSrc   = alu_src_reg;
    assign bus.op       = op_reg;
    assign bus.MemRead  = mem_read_reg;
    assign bus.MemWrite = mem_write_reg;
    assign bus.Mem2Reg  = mem2reg_reg;

    // Register-file write and memory requests are mutually exclusive
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0({reg_write_reg, mem_read_reg, mem_write_reg}));
        end
    end

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Self-checking bench for y_mc_ctrl: directed cases plus randomized instruction
// stream checked cycle by cycle against a per-class timing/outcome model.
module tb_y_mc_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    y_mc_ctrl_if #(.CNT_W(32)) bus ();

    y_mc_ctrl #(.RESET_PC(32'h28), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    // Instruction kinds used by the model
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BEQ = 4, K_JAL = 5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Mem2Reg};
    endfunction

    // Expected ALU op straight from the instruction-set table
    function automatic logic [2:0] exp_op(input int kind, input logic [2:0] f3, input logic f7b);
        if (kind == K_BEQ) return 3'b110;
        if (kind != K_R && kind != K_I) return 3'b010;
        case (f3)
            3'b000:  return (kind == K_R && f7b) ? 3'b110 : 3'b010;
            3'b111:  return 3'b000;
            3'b110:  return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic int kind_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h33:   return K_R;
            7'h13:   return K_I;
            7'h03:   return K_LD;
            7'h23:   return K_ST;
            7'h63:   return K_BEQ;
            default: return K_JAL;
        endcase
    endfunction

    // Run one legal instruction from its FETCH cycle to the next FETCH,
    // checking every cycle's outputs and the final PC/retired update.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int k,
                             input logic [31:0] br, input logic [31:0] jt);
        int          kind;
        int          mem_cycles;
        int          wb;
        int          total;
        logic [31:0] pc0;
        logic [31:0] new_pc;
        logic [2:0]  eop;
        logic        esrc;
        logic [3:0]  es;
        bit          in_mem;
        bit          in_wb;
        kind       = kind_of(ins);
        pc0        = m_pc;
        eop        = exp_op(kind, ins[14:12], ins[30]);
        esrc       = !(kind == K_R || kind == K_BEQ);
        mem_cycles = (kind == K_LD || kind == K_ST) ? k + 1 : 0;
        wb         = (kind != K_ST && kind != K_BEQ) ? 1 : 0;
        total      = 3 + mem_cycles + wb;
        bus.ins     = ins;
        bus.zero    = z;
        bus.PCp4    = pc0 + 32'd4;
        bus.branch  = br;
        bus.jTarget = jt;
        for (int c = 1; c <= total; c++) begin
            in_mem = (c > 3) && (c <= 3 + mem_cycles);
            in_wb  = (wb == 1) && (c == total);
            bus.dm_ready = in_mem ? (c == 3 + mem_cycles) : 1'($urandom_range(0, 1));
            es = 4'b0000;
            if (in_mem) es = (kind == K_LD) ? 4'b0100 : 4'b0010;
            if (in_wb)  es = {1'b1, 2'b00, (kind == K_LD)};
            check("strobes", {28'd0, strobes()}, {28'd0, es});
            check("pc_hold", bus.PCin, pc0);
            check("onehot", {31'd0, $onehot0({bus.RegWrite, bus.MemRead, bus.MemWrite})}, 32'd1);
            if (c == 3 || in_wb) begin
                check("op", {29'd0, bus.op}, {29'd0, eop});
                check("alusrc", {31'd0, bus.ALUSrc}, {31'd0, esrc});
            end
            if (in_mem) begin
                check("mem_op", {29'd0, bus.op}, 32'd2);
                check("mem_alusrc", {31'd0, bus.ALUSrc}, 32'd1);
            end
            tick();
        end
        if (kind == K_BEQ)      new_pc = z ? br : pc0 + 32'd4;
        else if (kind == K_JAL) new_pc = jt;
        else                    new_pc = pc0 + 32'd4;
        m_pc  = new_pc;
        m_ret = m_ret + 32'd1;
        check("pc_next", bus.PCin, m_pc);
        check("retired", bus.retired, m_ret);
        $display("TXN kind=%0d ins=%h k=%0d zero=%0d cycles=%0d pc=%h->%h retired=%0d",
                 kind, ins, k, z, total, pc0, bus.PCin, bus.retired);
    endtask

    // Assert reset mid-cycle, confirm it acts without a clock, then release at FETCH
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_pc"}, bus.PCin, 32'h28);
        check({tag, "_retired"}, bus.retired, 32'd0);
        check({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
        check({tag, "_strobes"}, {28'd0, strobes()}, 32'd0);
        check({tag, "_op"}, {29'd0, bus.op}, 32'd2);
        check({tag, "_alusrc"}, {31'd0, bus.ALUSrc}, 32'd0);
        tick();
        rst   = 1'b0;
        m_pc  = 32'h28;
        m_ret = 32'd0;
        $display("TXN reset %s pc=%h", tag, bus.PCin);
    endtask

    initial begin
        logic [31:0] traps [3];
        logic [31:0] rins;
        logic [2:0]  f3;
        int          kind;
        logic [31:0] pc_frozen;
        logic [31:0] ret_frozen;

        rst          = 1'b1;
        bus.ins      = 32'd0;
        bus.zero     = 1'b0;
        bus.PCp4     = 32'd0;
        bus.branch   = 32'd0;
        bus.jTarget  = 32'd0;
        bus.dm_ready = 1'b0;
        repeat (3) tick();
        do_reset("reset0");

        // Directed ALU cases
        run_instr(32'h002081B3, 1'b0, 0, 32'h100, 32'h200);   // add
        run_instr(32'h402081B3, 1'b0, 0, 32'h100, 32'h200);   // sub
        run_instr(32'h0020E1B3, 1'b0, 0, 32'h100, 32'h200);   // or
        // lw with three wait cycles
        run_instr(32'h0000A183, 1'b0, 3, 32'h100, 32'h200);
        // beq taken then not taken
        run_instr(32'h00208063, 1'b1, 0, 32'h40, 32'h200);
        run_instr(32'h00208063, 1'b0, 0, 32'h80, 32'h200);

        // Randomized legal instruction stream
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 5));
            rins = $urandom;
            case (kind)
                K_R:   rins[6:0] = 7'h33;
                K_I:   rins[6:0] = 7'h13;
                K_LD:  rins[6:0] = 7'h03;
                K_ST:  rins[6:0] = 7'h23;
                K_BEQ: rins[6:0] = 7'h63;
                default: rins[6:0] = 7'h6F;
            endcase
            if (kind == K_R || kind == K_I) begin
                case ($urandom_range(0, 3))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b111;
                    2:       f3 = 3'b110;
                    default: f3 = 3'b010;
                endcase
                rins[14:12] = f3;
            end
            if (kind == K_BEQ) rins[14:12] = 3'b000;
            run_instr(rins, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                      $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end

        // Illegal opcode, illegal R funct3, beq with nonzero funct3
        traps[0] = 32'h0000007F;
        traps[1] = 32'h002091B3;
        traps[2] = 32'h00209063;
        for (int t = 0; t < 3; t++) begin
            pc_frozen   = m_pc;
            ret_frozen  = m_ret;
            bus.ins     = traps[t];
            bus.PCp4    = m_pc + 32'd4;
            for (int c = 1; c <= 3; c++) begin
                bus.dm_ready = 1'($urandom_range(0, 1));
                check("trap_entry_strobes", {28'd0, strobes()}, 32'd0);
                if (t == 0 && c == 3) check("trap_after_decode", {31'd0, bus.illegal}, 32'd1);
                tick();
            end
            for (int c = 0; c < 20; c++) begin
                bus.dm_ready = 1'($urandom_range(0, 1));
                bus.zero     = 1'($urandom_range(0, 1));
                check("trap_illegal", {31'd0, bus.illegal}, 32'd1);
                check("trap_strobes", {28'd0, strobes()}, 32'd0);
                check("trap_pc", bus.PCin, pc_frozen);
                check("trap_retired", bus.retired, ret_frozen);
                tick();
            end
            $display("TXN trap ins=%h pc=%h retired=%0d illegal=%0d",
                     traps[t], bus.PCin, bus.retired, bus.illegal);
            do_reset("trap_reset");
        end

        // sw stalled in MEM, then reset arrives
        run_instr(32'h002081B3, 1'b0, 0, 32'h0, 32'h0);
        bus.ins      = 32'h0020A023;
        bus.PCp4     = m_pc + 32'd4;
        bus.dm_ready = 1'b0;
        repeat (3) tick();
        check("sw_memwrite", {31'd0, bus.MemWrite}, 32'd1);
        tick();
        check("sw_memwrite_held", {31'd0, bus.MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        check("sw_rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        do_reset("sw_reset");
        // Controller must be back in FETCH with normal timing
        run_instr(32'h002081B3, 1'b0, 0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/y_mc_ctrl.md
Name: y_mc_ctrl

Overview:
- Multi-cycle control and PC sequencer sitting directly upstream of the yIF/yID/yEX/yDM/yWB datapath.
- Replaces bench-driven control: decodes `ins`, drives RegWrite/ALUSrc/op/MemRead/MemWrite/Mem2Reg, owns the PC register feeding yIF.PCin.
- Selects next PC from PCp4, branch or jTarget.
- Handshakes with data memory through dm_ready.

Parameters:
- RESET_PC, 32'h28, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ins  in  32  instruction from yIF.
- zero  in  1  ALU zero flag from yEX.
- PCp4  in  32  PC+4 from yIF.
- branch  in  32  branch target from yID.
- jTarget  in  32  jal target from yID.
- dm_ready  in  1  data memory completes current read/write this cycle.
- PCin  out  32  current PC to yIF.
- RegWrite  out  1  register-file write strobe.
- ALUSrc  out  1  0 = rd2, 1 = imm.
- op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- Mem2Reg  out  1  write-back select, 1 = memOut.
- illegal  out  1  sticky trap flag.
- retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate):
  - state=FETCH, PCin=RESET_PC, retired=0, illegal=0.
  - RegWrite/MemRead/MemWrite/Mem2Reg/ALUSrc=0, op=010.
- Control outputs are registered-state Moore decodes of state plus latched instruction class. No output depends combinationally on ins.
- FETCH (1 cycle): all strobes 0. Goes to DECODE.
- DECODE (1 cycle): latch ins[31:0] into IR; classify opcode IR[6:0]:
  - 0x33 R
  - 0x13 I-ALU
  - 0x03 LOAD
  - 0x23 STORE
  - 0x63 BEQ (funct3 000 only)
  - 0x6F JAL
  - anything else, or 0x63 with funct3≠000, goes to TRAP.
  - Otherwise goes to EXEC.
- EXEC (1 cycle):
  - ALUSrc=0 for R and BEQ, 1 otherwise.
  - op from ALU decoder:
    - R: f3=000 gives add (f7[5]=0) or sub (f7[5]=1); f3=111 and; f3=110 or; f3=010 slt; other f3 goes to TRAP.
    - I-ALU: same mapping, no sub.
    - LOAD/STORE/JAL: add. BEQ: sub.
  - Next state:
    - R/I-ALU/JAL go to WB.
    - LOAD/STORE go to MEM.
    - BEQ performs the PC update (branch if zero=1, else PCp4) and goes to FETCH.
- MEM: ALUSrc=1, op=add held.
  - MemRead=1 (LOAD) or MemWrite=1 (STORE), held until the cycle dm_ready=1 is sampled; that cycle counts as the access.
  - LOAD then goes to WB.
  - STORE performs the PC update (PCp4) and goes to FETCH.
  - No timeout; dm_ready during FETCH/DECODE/EXEC is ignored.
- WB (1 cycle): RegWrite=1, Mem2Reg=1 only for LOAD, ALU controls held from EXEC. PC update: jTarget for JAL, PCp4 otherwise. Goes to FETCH.
- PC update means PCin and retired (+1, wrap) change at the same clock edge.
- Per-class latency, FETCH to next FETCH:
  - R/I/JAL: 4 cycles.
  - BEQ: 3 cycles.
  - STORE: 4+k cycles. LOAD: 5+k cycles. k = extra cycles waiting on dm_ready.
- TRAP: illegal=1, all strobes 0, PCin and retired frozen. Left only by reset.
- At most one of RegWrite/MemRead/MemWrite is high in any cycle (must hold as an assertion).
- Reset mid-MEM drops MemWrite/MemRead asynchronously; no partial write is signalled after rst rises.

Decomposition:
- Package y_ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - opcode constants: OPC_R, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BEQ, OPC_JAL.
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - instruction-class enum.
- One sub-module, y_alu_dec: combinational; class + funct3 + funct7[5] in, op[2:0] + bad_funct out.

Test Plan:
- Reset, then R-type add (ins=32'h002081B3) at PC 0x28, PCp4=0x2C:
  - op=010 and ALUSrc=0 in EXEC.
  - RegWrite=1 only in cycle 4.
  - PCin=0x2C and retired=1 after 4 cycles.
- R-type sub (funct7=0x20, e.g. 32'h402081B3) → op=110 in EXEC; R-type or (f3=110) → op=001.
- lw (ins=32'h0000A183) with dm_ready held low 3 MEM cycles:
  - MemRead=1 for exactly 4 cycles.
  - WB shows RegWrite=1, Mem2Reg=1.
  - PC advances after 8 total cycles.
- beq with zero=1, branch=0x40 → PCin=0x40 after 3 cycles, RegWrite never asserted. Repeat with zero=0 → PCin=PCp4.
- ins opcode 0x7F → TRAP after DECODE:
  - illegal=1, strobes 0.
  - PCin and retired unchanged over 20 cycles.
  - rst clears to PCin=0x28, illegal=0.
- sw with dm_ready low, rst asserted mid-MEM → MemWrite falls the same timestep, PCin=0x28, state FETCH, retired=0.
